// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter for the UART TX path; optional parity bit when PISO_PARITY_EN is defined.
// Latency: first bit on bit_out one cycle after the load handshake; each bit is held until a shift_en edge consumes it.
// Backpressure: load_ready is low while a frame is in flight; done pulses in the cycle load_ready returns high.
module piso_shifter #(
    parameter int  DATA_WIDTH = 8,
    parameter int  MSB_FIRST  = 0,
    parameter int  PARITY_ODD = 0,
    localparam int IDX_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic [IDX_W-1:0]      bit_idx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic       PAR_INV   = (PARITY_ODD != 0);
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    // Reject illegal configurations at elaboration rather than building a broken shifter.
    if (DATA_WIDTH < 1 || DATA_WIDTH > 32 || MSB_FIRST < 0 || MSB_FIRST > 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("piso_shifter: parameter out of range");
    end

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic [IDX_W-1:0]      cnt;
    logic                  load_fire;
    logic                  first_bit;
    logic                  next_bit;
`ifdef PISO_PARITY_EN
    logic                  par_q;
`endif

    // Ready is masked by reset so a word offered during reset is never taken.
    assign load_ready = (state == ST_IDLE) && !srst;
    assign load_fire  = load_valid && load_ready;

    // The shift register always keeps the bit on bit_out at its output end.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shreg_nxt = shreg << 1;
        end else begin
            shreg_nxt = shreg >> 1;
        end
    end

    assign first_bit = (MSB_FIRST != 0) ? load_data[DATA_WIDTH-1] : load_data[0];
    assign next_bit  = (MSB_FIRST != 0) ? shreg_nxt[DATA_WIDTH-1] : shreg_nxt[0];

    // Frame sequencer: all outputs are registered and updated alongside the state.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            bit_out   <= 1'b1;
            bit_valid <= 1'b0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // shift_en is deliberately ignored here, including in the load cycle.
                    if (load_fire) begin
                        state     <= ST_SHIFT;
                        shreg     <= load_data;
                        cnt       <= '0;
                        bit_out   <= first_bit;
                        bit_valid <= 1'b1;
                        bit_idx   <= '0;
                        busy      <= 1'b1;
`ifdef PISO_PARITY_EN
                        par_q     <= (^load_data) ^ PAR_INV;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (shift_en) begin
                        if (cnt == LAST_IDX) begin
`ifdef PISO_PARITY_EN
                            state   <= ST_PARITY;
                            cnt     <= cnt + IDX_W'(1);
                            bit_out <= par_q;
                            bit_idx <= cnt + IDX_W'(1);
`else
                            state     <= ST_IDLE;
                            cnt       <= '0;
                            bit_out   <= 1'b1;
                            bit_valid <= 1'b0;
                            bit_idx   <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else begin
                            cnt     <= cnt + IDX_W'(1);
                            shreg   <= shreg_nxt;
                            bit_out <= next_bit;
                            bit_idx <= cnt + IDX_W'(1);
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    if (shift_en) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        bit_out   <= 1'b1;
                        bit_valid <= 1'b0;
                        bit_idx   <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
